// File: rtl/slow_mem_if.sv
// Cache-to-memory block request interface.
// master: the requester (cache controller) drives the request, address and write data.
// slave:  the memory responder drives the read data and the completion pulse.
//   mem_read / mem_write : block request lines, held by the requester until mem_ready
//   mem_addr             : 28-bit block address
//   mem_wdata            : 128-bit write block
//   mem_rdata            : 128-bit read block, valid while mem_ready is high
//   mem_ready            : one-cycle completion pulse
interface slow_mem_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/slow_mem_responder.sv
// Synthesizable slow block memory that answers cache read/write requests after a
// fixed LATENCY with a one-cycle mem_ready pulse, and keeps saturating read/write
// completion counts plus a sticky protocol-error flag.
// Ports:
//   clk       : system clock, all state updates on its rising edge
//   rst       : synchronous active-low reset
//   bus       : slave side of slow_mem_if (request lines, address, data, ready)
//   rd_count  : completed reads, saturating at 0xFFFF
//   wr_count  : completed writes, saturating at 0xFFFF
//   proto_err : set when read and write are requested together; cleared only by reset
//
// state | meaning
// IDLE  | waiting for exactly one of mem_read / mem_write
// BUSY  | request latched, latency counter running down
// RESP  | mem_ready high for this single cycle
module slow_mem_responder #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 64,
    parameter int AW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    slow_mem_if.slave   bus,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t         state, state_next;
    logic [7:0]     cnt, cnt_next;
    logic           req_write;
    logic [AW-1:0]  req_idx;
    logic [127:0]   req_wdata;
    logic [127:0]   rdata_q;
    logic [127:0]   mem [DEPTH];

    logic           accept;
    logic           commit;
    logic           both_req;
    logic           cmt_write;
    logic [AW-1:0]  cmt_idx;
    logic [127:0]   cmt_wdata;

    // Upper address bits alias onto the same entries.
    logic unused_addr;
    assign unused_addr = ^bus.mem_addr[27:AW];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        both_req   = 1'b0;
        // With LATENCY==1 the commit happens on the accept edge, so the
        // request has to come straight from the bus rather than the latches.
        cmt_write  = req_write;
        cmt_idx    = req_idx;
        cmt_wdata  = req_wdata;
        case (state)
            IDLE: begin
                cmt_write = bus.mem_write;
                cmt_idx   = bus.mem_addr[AW-1:0];
                cmt_wdata = bus.mem_wdata;
                if (bus.mem_read && bus.mem_write) begin
                    both_req = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    accept   = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Abort takes priority over completion on the final edge.
                if (!(req_write ? bus.mem_write : bus.mem_read)) begin
                    state_next = IDLE;
                end else if (cnt == 8'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_write <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            rdata_q   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (both_req) begin
                proto_err <= 1'b1;
            end
            if (accept) begin
                req_write <= bus.mem_write;
                req_idx   <= bus.mem_addr[AW-1:0];
                req_wdata <= bus.mem_wdata;
            end
            if (commit) begin
                if (cmt_write) begin
                    mem[cmt_idx] <= cmt_wdata;
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end else begin
                    rdata_q <= mem[cmt_idx];
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = (state == RESP);

endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: directed vector table, randomized transactions
// against a transaction-level memory model, and hand-written multi-cycle
// sequences (held request, LATENCY=1 instance, reset mid-write).
module tb_slow_mem_responder;

    localparam int LAT8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    slow_mem_if bus8();
    slow_mem_if bus1();
    logic [15:0] rdc8, wrc8, rdc1, wrc1;
    logic        perr8, perr1;

    slow_mem_responder #(.LATENCY(LAT8), .DEPTH(64), .AW(6)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .rd_count(rdc8), .wr_count(wrc8), .proto_err(perr8)
    );

    slow_mem_responder #(.LATENCY(1), .DEPTH(64), .AW(6)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .rd_count(rdc1), .wr_count(wrc1), .proto_err(perr1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, last read block, counts, error flag.
    logic [127:0] m_mem [64];
    logic [127:0] m_last_rd;
    int           m_rd, m_wr;
    logic         m_perr;

    localparam int OP_RD = 0, OP_WR = 1, OP_ABORT = 2, OP_BOTH = 3;

    typedef struct {
        int           op;
        logic [27:0]  addr;
        logic [127:0] data;
        int           drop;
        logic [127:0] exp_rdata;
        logic [15:0]  exp_rd;
        logic [15:0]  exp_wr;
        logic         exp_perr;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_last_rd = '0;
        m_rd = 0;
        m_wr = 0;
        m_perr = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_apply(input int op, input logic [27:0] addr, input logic [127:0] data);
        case (op)
            OP_RD: begin
                m_last_rd = m_mem[addr % 64];
                m_rd = sat_inc(m_rd);
            end
            OP_WR: begin
                m_mem[addr % 64] = data;
                m_wr = sat_inc(m_wr);
            end
            OP_BOTH: m_perr = 1'b1;
            default: ;
        endcase
    endtask

    task automatic drop8();
        bus8.mem_read  = 1'b0;
        bus8.mem_write = 1'b0;
    endtask

    // Drives one transaction on the LATENCY=8 instance. n counts negedges after
    // the acceptance edge E0; the ready pulse belongs at n == LAT8.
    task automatic run_txn(input int op, input logic [27:0] addr, input logic [127:0] data,
                           input int drop_at, output int pulses, output int first_n,
                           output logic [127:0] rdata_seen);
        pulses = 0;
        first_n = 0;
        rdata_seen = 'x;
        @(posedge clk); #1;
        bus8.mem_addr  = addr;
        bus8.mem_wdata = data;
        bus8.mem_read  = (op == OP_RD || op == OP_BOTH);
        bus8.mem_write = (op != OP_RD);
        @(posedge clk);
        for (int n = 1; n <= LAT8 + 4; n++) begin
            #1;
            if (op == OP_BOTH && n == 1) drop8();
            if (op == OP_ABORT && n - 1 == drop_at) drop8();
            if ((op == OP_RD || op == OP_WR) && pulses > 0) drop8();
            @(negedge clk);
            if (bus8.mem_ready === 1'b1) begin
                pulses++;
                if (first_n == 0) begin
                    first_n = n;
                    rdata_seen = bus8.mem_rdata;
                end
            end
            @(posedge clk);
        end
        #1;
        drop8();
    endtask

    vec_t vecs[9];
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, first_n, p1, p2;
        logic [127:0] rd_seen, d1, d2;
        logic [27:0] a;

        vecs[0] = '{OP_WR,    28'd5,  D1, 0, 128'd0, 16'd0, 16'd1, 1'b0};
        vecs[1] = '{OP_RD,    28'd5,  '0, 0, D1,     16'd1, 16'd1, 1'b0};
        vecs[2] = '{OP_RD,    28'd69, '0, 0, D1,     16'd2, 16'd1, 1'b0};
        vecs[3] = '{OP_ABORT, 28'd5,  D2, 3, '0,     16'd2, 16'd1, 1'b0};
        vecs[4] = '{OP_RD,    28'd5,  '0, 0, D1,     16'd3, 16'd1, 1'b0};
        vecs[5] = '{OP_BOTH,  28'd5,  D2, 0, '0,     16'd3, 16'd1, 1'b1};
        vecs[6] = '{OP_RD,    28'd5,  '0, 0, D1,     16'd4, 16'd1, 1'b1};
        vecs[7] = '{OP_WR,    28'd71, D2, 0, D1,     16'd4, 16'd2, 1'b1};
        vecs[8] = '{OP_RD,    28'd7,  '0, 0, D2,     16'd5, 16'd2, 1'b1};

        bus8.mem_read = 0; bus8.mem_write = 0; bus8.mem_addr = '0; bus8.mem_wdata = '0;
        bus1.mem_read = 0; bus1.mem_write = 0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("reset_rdata", bus8.mem_rdata, 0);
        chk("reset_ready", bus8.mem_ready, 0);
        chk("reset_rd_count", rdc8, 0);
        chk("reset_wr_count", wrc8, 0);
        chk("reset_proto_err", perr8, 0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].drop, pulses, first_n, rd_seen);
            model_apply(vecs[i].op, vecs[i].addr, vecs[i].data);
            @(negedge clk);
            if (vecs[i].op == OP_RD || vecs[i].op == OP_WR) begin
                chk($sformatf("vec%0d_pulses", i), pulses, 1);
                chk($sformatf("vec%0d_latency", i), first_n, LAT8);
                chk($sformatf("vec%0d_rdata", i), rd_seen, vecs[i].exp_rdata);
            end else begin
                chk($sformatf("vec%0d_no_ready", i), pulses, 0);
            end
            chk($sformatf("vec%0d_rd_count", i), rdc8, vecs[i].exp_rd);
            chk($sformatf("vec%0d_wr_count", i), wrc8, vecs[i].exp_wr);
            chk($sformatf("vec%0d_proto_err", i), perr8, vecs[i].exp_perr);
        end

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            int r, op, drop;
            logic [127:0] wd;
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_RD : (r < 8) ? OP_WR : (r == 8) ? OP_ABORT : OP_BOTH;
            a = 28'($urandom);
            if (t % 3 == 0) a[5:0] = 6'($urandom_range(0, 3));
            wd = {$urandom, $urandom, $urandom, $urandom};
            drop = $urandom_range(0, LAT8 - 2);
            run_txn(op, a, wd, drop, pulses, first_n, rd_seen);
            model_apply(op, a, wd);
            @(negedge clk);
            if (op == OP_RD || op == OP_WR) begin
                chk($sformatf("rnd%0d_pulses", t), pulses, 1);
                chk($sformatf("rnd%0d_latency", t), first_n, LAT8);
                chk($sformatf("rnd%0d_rdata", t), rd_seen, m_last_rd);
            end else begin
                chk($sformatf("rnd%0d_no_ready", t), pulses, 0);
            end
            chk($sformatf("rnd%0d_rd_count", t), rdc8, m_rd);
            chk($sformatf("rnd%0d_wr_count", t), wrc8, m_wr);
            chk($sformatf("rnd%0d_proto_err", t), perr8, m_perr);
        end

        // Read held across two responses: pulses at LAT8 and 2*LAT8+1
        a = 28'd2;
        p1 = 0; p2 = 0; d1 = 'x; d2 = 'x;
        @(posedge clk); #1;
        bus8.mem_addr = a; bus8.mem_read = 1'b1; bus8.mem_write = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 3 * LAT8; n++) begin
            @(negedge clk);
            if (bus8.mem_ready === 1'b1) begin
                if (p1 == 0) begin p1 = n; d1 = bus8.mem_rdata; end
                else if (p2 == 0) begin p2 = n; d2 = bus8.mem_rdata; end
            end
            @(posedge clk); #1;
            if (p2 != 0) break;
        end
        drop8();
        model_apply(OP_RD, a, '0);
        model_apply(OP_RD, a, '0);
        @(negedge clk);
        chk("held_first_latency", p1, LAT8);
        chk("held_spacing", p2 - p1, LAT8 + 1);
        chk("held_rdata1", d1, m_mem[2]);
        chk("held_rdata2", d2, m_mem[2]);
        chk("held_rd_count", rdc8, m_rd);

        // Reset in the middle of a write to addr 3
        @(posedge clk); #1;
        bus8.mem_addr = 28'd3; bus8.mem_wdata = D2; bus8.mem_write = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; drop8();
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_rdata", bus8.mem_rdata, 0);
        chk("rstmid_ready", bus8.mem_ready, 0);
        chk("rstmid_rd_count", rdc8, 0);
        chk("rstmid_wr_count", wrc8, 0);
        chk("rstmid_proto_err", perr8, 0);
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        pulses = 0;
        for (int n = 0; n < LAT8 + 3; n++) begin
            @(negedge clk);
            if (bus8.mem_ready === 1'b1) pulses++;
        end
        chk("rstmid_no_ready", pulses, 0);
        run_txn(OP_RD, 28'd3, '0, 0, pulses, first_n, rd_seen);
        model_apply(OP_RD, 28'd3, '0);
        @(negedge clk);
        chk("rstmid_read_pulses", pulses, 1);
        chk("rstmid_read_data", rd_seen, 0);
        chk("rstmid_read_count", rdc8, m_rd);

        // LATENCY=1 instance: write then held read, pulses 1 and 3 after acceptance
        @(posedge clk); #1;
        bus1.mem_addr = 28'd9; bus1.mem_wdata = D1; bus1.mem_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("lat1_write_ready", bus1.mem_ready, 1);
        @(posedge clk); #1;
        bus1.mem_write = 1'b0;
        @(negedge clk);
        chk("lat1_write_pulse_width", bus1.mem_ready, 0);
        chk("lat1_wr_count", wrc1, 1);
        @(posedge clk); #1;
        bus1.mem_addr = 28'd73; bus1.mem_read = 1'b1;
        @(posedge clk);
        p1 = 0; p2 = 0; d1 = 'x;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (bus1.mem_ready === 1'b1) begin
                if (p1 == 0) begin p1 = n; d1 = bus1.mem_rdata; end
                else if (p2 == 0) p2 = n;
            end
            @(posedge clk); #1;
            if (p2 != 0) break;
        end
        bus1.mem_read = 1'b0;
        @(negedge clk);
        chk("lat1_first_latency", p1, 1);
        chk("lat1_spacing", p2 - p1, 2);
        chk("lat1_rdata", d1, D1);
        chk("lat1_rd_count", rdc1, 2);
        chk("lat1_proto_err", perr1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
